alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand/result width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester n's operation accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  4  ALU opcode from requester n.
REQ-007 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands from requester n.
REQ-008 SHALL have ports alu_op  output  4, alu_in1 and alu_in2  output  DATA_W  registered drive to the shared ALU.
REQ-009 SHALL have ports alu_result  input  DATA_W, alu_v, alu_z, alu_c, alu_s  input  1  combinational ALU outputs.
REQ-010 SHALL have ports rsp_valid  output  1, rsp_ready  input  1  response handshake.
REQ-011 SHALL have ports rsp_id  output  1  (requester index), rsp_result  output  DATA_W, rsp_flags  output  4  ({v,z,c,s}).

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 In IDLE with at least one reqN_valid, SHALL grant exactly one requester, pulse its reqN_ready for that cycle only, register its op/a/b into alu_op/alu_in1/alu_in2, and go to EXEC.
REQ-014 Arbitration SHALL be round-robin: with only one valid, grant it; with both valid, grant the requester not granted last.
REQ-015 last_grant SHALL update only on a grant; reset value 1, so requester 0 wins the first tie.
REQ-016 reqN_ready SHALL be 0 in EXEC and RESP, and 0 in IDLE for a non-granted requester.
REQ-017 In EXEC, SHALL capture alu_result into rsp_result and {alu_v,alu_z,alu_c,alu_s} into rsp_flags, set rsp_id to the granted index, set rsp_valid, and go to RESP.
REQ-018 In RESP, rsp_valid/rsp_id/rsp_result/rsp_flags SHALL hold stable until rsp_valid and rsp_ready are both high; on that edge rsp_valid clears and FSM goes to IDLE.
REQ-019 Acceptance-to-rsp_valid latency SHALL be 2 cycles; minimum spacing between grants SHALL be 3 cycles.
REQ-020 alu_op/alu_in1/alu_in2 SHALL hold their last granted values outside the grant cycle.
REQ-021 Opcode SHALL be passed through unmodified; undefined opcodes (7, 13-15) SHALL be forwarded, and whatever the ALU returns SHALL be reported.
REQ-022 A requester dropping valid while not granted SHALL lose no state; nothing is queued.

Reset
REQ-023 rst high SHALL immediately force FSM=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, alu_op=0, alu_in1=0, alu_in2=0, last_grant=1, reqN_ready=0.
REQ-024 rst asserted in EXEC or RESP SHALL discard the in-flight operation, and no response SHALL be produced for it.
REQ-025 The first grant after rst deassertion SHALL occur no earlier than the first rising edge with rst low.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, DATA_W, opcode width 4, and flag bit indices (V=3, Z=2, C=1, S=0).
REQ-027 The round-robin picker SHALL be the sub-module rr_pick2 (inputs: two valids, last_grant; outputs: grant, grant_idx).
REQ-028 The ALU SHALL NOT be instantiated inside alu_arbiter; it is connected at the parent level.

Verification
REQ-029 Bench: only req0 add (op 0), a=0x7FFF, b=0x0001 -> req0_ready pulses once; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=0x8000, flag V=1, Z=0.
REQ-030 Bench: both valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0, spaced 3 cycles apart.
REQ-031 Bench: req1 cmp (op 5), a=b=0x0005, rsp_ready=0 for 10 cycles -> rsp_valid, rsp_result=0x0000 and Z=1 held for all 10 cycles; req0/req1 ready stay 0 throughout.
REQ-032 Bench: rst pulsed one cycle during EXEC of req0 op 2, a=0xF0F0, b=0x0FF0 -> no rsp_valid; all outputs 0; next tie grants requester 0.
REQ-033 Bench: req0 op 15, a=0x1234, b=0x0001 -> alu_op=15 driven; rsp_result equals the ALU's returned value (0x0000 with the team ALU).

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the two-requester ALU arbiter:
//   - FSM state encoding
//   - operand/result width and opcode width
//   - bit positions of the {v,z,c,s} flag nibble
// No ports; imported by alu_arbiter and rr_pick2.
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;

    // Operand/result width of the shared ALU; only 16 is supported.
    localparam int DATA_W = 16;

    // Opcode width; opcodes are forwarded to the ALU without decoding.
    localparam int OP_W = 4;

    // Number of flag bits and their positions within rsp_flags.
    localparam int FLAG_W = 4;
    localparam int FLAG_V = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 0;

    // Requester index values.
    localparam logic REQ_IDX_0 = 1'b0;
    localparam logic REQ_IDX_1 = 1'b1;

    // Arbiter FSM: IDLE waits for a request, EXEC samples the ALU,
    // RESP holds the response until it is consumed.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Pack the four ALU status bits into the flag nibble layout.
    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic v,
        input logic z,
        input logic c,
        input logic s
    );
        logic [FLAG_W-1:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_S] = s;
        return f;
    endfunction

endpackage : alu_arbiter_pkg

// File: rtl/alu_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin picker, purely combinational.
//   valid0, valid1 : request pending from requester 0 / 1
//   last_grant     : index granted most recently
//   grant          : high when some requester is selected this cycle
//   grant_idx      : selected requester index (meaningful only with grant)
// A lone valid always wins; on a tie the requester not granted last wins.
// -----------------------------------------------------------------------------
module rr_pick2
    import alu_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant,
    output logic grant_idx
);

    always_comb begin
        grant     = valid0 | valid1;
        grant_idx = REQ_IDX_0;
        if (valid0 && valid1) begin
            grant_idx = ~last_grant;
        end else if (valid1) begin
            grant_idx = REQ_IDX_1;
        end
    end

endmodule : rr_pick2

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one external combinational ALU between two requesters.
// A requester is accepted in IDLE (reqN_ready pulses for that cycle), its
// opcode/operands are registered onto the ALU drive, the ALU outputs are
// sampled one cycle later, and the response is held until rsp_ready.
//
// Ports
//   clk, rst                    : clock, asynchronous active-high reset
//   reqN_valid / reqN_ready     : request handshake for requester N (0,1)
//   reqN_op, reqN_a, reqN_b     : opcode and operands from requester N
//   alu_op, alu_in1, alu_in2    : registered drive to the shared ALU
//   alu_result, alu_v/z/c/s     : combinational ALU outputs
//   rsp_valid / rsp_ready       : response handshake
//   rsp_id, rsp_result,
//   rsp_flags ({v,z,c,s})       : response payload
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = alu_arbiter_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_v,
    input  logic              alu_z,
    input  logic              alu_c,
    input  logic              alu_s,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [FLAG_W-1:0] rsp_flags
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    arb_state_e        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic [OP_W-1:0]   alu_op_q,     alu_op_d;
    logic [DATA_W-1:0] alu_in1_q,    alu_in1_d;
    logic [DATA_W-1:0] alu_in2_q,    alu_in2_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic              rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_flags_q,  rsp_flags_d;

    logic pick_grant;
    logic pick_idx;
    logic grant_now;

    // -------------------------------------------------------------------------
    // Round-robin selection between the two requesters
    // -------------------------------------------------------------------------
    rr_pick2 u_rr_pick2 (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .grant_idx  (pick_idx)
    );

    // A grant only happens in IDLE. rst is folded in so that ready stays low
    // while reset is held, even though the state register already reads IDLE.
    assign grant_now = (state_q == ST_IDLE) && pick_grant && !rst;

    always_comb begin
        req0_ready = grant_now && (pick_idx == REQ_IDX_0);
        req1_ready = grant_now && (pick_idx == REQ_IDX_1);
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath capture
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        alu_op_d     = alu_op_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_now) begin
                    // Opcode is forwarded untouched, including undefined codes.
                    last_grant_d = pick_idx;
                    if (pick_idx == REQ_IDX_1) begin
                        alu_op_d  = req1_op;
                        alu_in1_d = req1_a;
                        alu_in2_d = req1_b;
                    end else begin
                        alu_op_d  = req0_op;
                        alu_in1_d = req0_a;
                        alu_in2_d = req0_b;
                    end
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // ALU inputs have been stable for a full cycle; sample outputs.
                // last_grant_q holds the index of the in-flight requester.
                rsp_result_d = alu_result;
                rsp_flags_d  = pack_flags(alu_v, alu_z, alu_c, alu_s);
                rsp_id_d     = last_grant_q;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers. Reset clears every output so an in-flight operation is
    // discarded without a response.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_IDX_1;
            alu_op_q     <= '0;
            alu_in1_q    <= '0;
            alu_in2_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            alu_op_q     <= alu_op_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_op     = alu_op_q;
    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule : alu_arbiter
